// File: rtl/tx_sched_pkg.sv
// ============================================================================
// tx_sched_pkg : shared types and width helpers for the transmit scheduler
// Revision     : 1.0
// ============================================================================
`default_nettype none

package tx_sched_pkg;

  localparam int BYTE_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  // Counter/pointer width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_sched_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin search, first set request at or
//              above the pointer (with wrap) wins
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = cnt_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  localparam logic [PTR_W:0] C_NREQ = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0] pos_w;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    pos_w   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_w = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (pos_w >= C_NREQ) pos_w = pos_w - C_NREQ;
      if (!valid_o && req_i[pos_w[PTR_W-1:0]]) begin
        gnt_o[pos_w[PTR_W-1:0]] = 1'b1;
        valid_o                 = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_sched.sv
// ============================================================================
// tx_sched : round-robin scheduler feeding one serial transmit fsm,
//            start strobe, MSB-first bit stream, commit with timeout
// Revision : 1.0
// ============================================================================
`default_nettype none

module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BYTE_W  = BYTE_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic                      busy,
  input  logic                      transmit_ready,
  input  logic                      success,
  output logic                      tx_ctrl,
  output logic                      bit_out,
  output logic                      ready_signal
);

  localparam int PTR_W = cnt_w(NUM_REQ);
  localparam int BC_W  = cnt_w(BYTE_W);
  localparam int TC_W  = cnt_w(TIMEOUT);

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d, gidx_q, gidx_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d, ack_q, ack_d, err_q, err_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic [BC_W-1:0]      bcnt_q, bcnt_d;
  logic [TC_W-1:0]      tcnt_q, tcnt_d;
  logic                 tx_ctrl_q, tx_ctrl_d, bit_out_q, bit_out_d;
  logic                 ready_q, ready_d, busy_q, busy_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic                 arb_valid;
  logic [PTR_W-1:0]     arb_idx;
  logic [BYTE_W-1:0]    arb_byte;
  logic                 last_bit, timed_out, launch;
  logic [PTR_W-1:0]     ptr_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  always_comb begin
    arb_idx  = '0;
    arb_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        arb_idx  = arb_idx | PTR_W'(i);
        arb_byte = arb_byte | req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign launch    = transmit_ready && arb_valid;
  assign last_bit  = (bcnt_q == BC_W'(BYTE_W-1));
  assign timed_out = (tcnt_q == TC_W'(TIMEOUT-1));
  assign ptr_next  = (gidx_q == PTR_W'(NUM_REQ-1)) ? '0 : gidx_q + PTR_W'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      gnt_q     <= '0;
      shift_q   <= '0;
      bcnt_q    <= '0;
      tcnt_q    <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      tx_ctrl_q <= 1'b0;
      bit_out_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      gnt_q     <= gnt_d;
      shift_q   <= shift_d;
      bcnt_q    <= bcnt_d;
      tcnt_q    <= tcnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      tx_ctrl_q <= tx_ctrl_d;
      bit_out_q <= bit_out_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = START;
      START:   state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = COMMIT;
      COMMIT:  if (success || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded from the next state so they line up with state_q.
  always_comb begin
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    gnt_d     = gnt_q;
    shift_d   = shift_q;
    bcnt_d    = '0;
    tcnt_d    = '0;
    ack_d     = '0;
    err_d     = '0;
    bit_out_d = 1'b0;
    tx_ctrl_d = (state_d == START);
    ready_d   = !((state_d == START) || (state_d == SHIFT));
    busy_d    = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (launch) begin
          gnt_d   = arb_gnt;
          gidx_d  = arb_idx;
          shift_d = arb_byte;
        end
      end
      START: begin
        bit_out_d = shift_q[BYTE_W-1];
        shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
      end
      SHIFT: begin
        bcnt_d = bcnt_q + BC_W'(1);
        if (!last_bit) begin
          bit_out_d = shift_q[BYTE_W-1];
          shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
        end
      end
      COMMIT: begin
        tcnt_d = tcnt_q + TC_W'(1);
        if (success) begin
          ack_d = gnt_q;
          ptr_d = ptr_next;
        end else if (timed_out) begin
          err_d = gnt_q;
          ptr_d = ptr_next;
        end
      end
      default: ;
    endcase
  end

  assign ack          = ack_q;
  assign err          = err_q;
  assign busy         = busy_q;
  assign tx_ctrl      = tx_ctrl_q;
  assign bit_out      = bit_out_q;
  assign ready_signal = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_sched.sv
// ============================================================================
// tb_tx_sched : randomized self-checking bench for tx_sched against a
//               transaction-level round-robin model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_tx_sched;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*BW-1:0] req_data = '0;
  logic            transmit_ready = 1'b0;
  logic            success = 1'b0;
  logic [N-1:0]    ack, err;
  logic            busy, tx_ctrl, bit_out, ready_signal;

  int n_chk  = 0;
  int n_fail = 0;
  int mptr   = 0;

  tx_sched #(.NUM_REQ(N), .BYTE_W(BW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .req            (req),
    .req_data       (req_data),
    .ack            (ack),
    .err            (err),
    .busy           (busy),
    .transmit_ready (transmit_ready),
    .success        (success),
    .tx_ctrl        (tx_ctrl),
    .bit_out        (bit_out),
    .ready_signal   (ready_signal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_tx_ctrl"}, 32'(tx_ctrl), 32'd0);
    check_eq({tag, "_ready"},   32'(ready_signal), 32'd1);
    check_eq({tag, "_busy"},    32'(busy), 32'd0);
    check_eq({tag, "_ackerr"},  32'({ack, err}), 32'd0);
  endtask

  // Round-robin reference: first asserted request at or after the pointer.
  function automatic int model_grant();
    for (int k = 0; k < N; k++)
      if (req[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i);
    req_data[i*BW +: BW] = 8'($urandom);
    req[i] = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge showing ack/err.
  task automatic run_xfer(input int tr_wait, input int succ_dly, input bit drop_early, input bit noise);
    int           g;
    logic [BW-1:0] b;
    logic [N-1:0] oh;
    g = model_grant();
    if (g < 0) return;
    b  = req_data[g*BW +: BW];
    oh = N'(1) << g;
    transmit_ready = (tr_wait == 0);
    for (int w = 0; w < tr_wait; w++) begin
      @(negedge clk);
      check_idle("wait_ready");
      if (w == tr_wait - 1) transmit_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("start_tx_ctrl", 32'(tx_ctrl), 32'd1);
    check_eq("start_ready",   32'(ready_signal), 32'd0);
    check_eq("start_busy",    32'(busy), 32'd1);
    check_eq("start_bit",     32'(bit_out), 32'd0);
    transmit_ready = 1'($urandom);
    for (int k = 0; k < BW; k++) begin
      @(negedge clk);
      check_eq($sformatf("bit%0d", BW - 1 - k), 32'(bit_out), 32'(b[BW-1-k]));
      check_eq("shift_ctl", 32'({tx_ctrl, ready_signal}), 32'd0);
      success = noise && (k == 2);
    end
    success = 1'b0;
    if (drop_early) req[g] = 1'b0;
    if (succ_dly >= 0) begin
      for (int c = 0; c <= succ_dly; c++) begin
        @(negedge clk);
        check_eq("commit_state", 32'({ready_signal, busy, bit_out}), 32'b110);
        check_eq("commit_noack", 32'({ack, err}), 32'd0);
        if (c == succ_dly) success = 1'b1;
      end
      @(negedge clk);
      success = 1'b0;
      check_eq("ack", 32'(ack), 32'(oh));
      check_eq("ack_noerr", 32'(err), 32'd0);
    end else begin
      for (int c = 0; c < TO; c++) begin
        @(negedge clk);
        check_eq("to_state", 32'({ready_signal, busy, bit_out}), 32'b110);
        check_eq("to_noackerr", 32'({ack, err}), 32'd0);
      end
      @(negedge clk);
      check_eq("err", 32'(err), 32'(oh));
      check_eq("err_noack", 32'(ack), 32'd0);
    end
    check_eq("done_busy", 32'(busy), 32'd0);
    req[g] = 1'b0;
    mptr = (g + 1) % N;
    transmit_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_eq("reset_bit", 32'(bit_out), 32'd0);
    nrst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_idle("idle_noreq");
    end

    req_data[7:0] = 8'hCB;
    req = 4'b0001;
    run_xfer(0, 3, 1'b0, 1'b0);

    set_req(2);
    run_xfer(4, 1, 1'b0, 1'b0);

    set_req(3);
    run_xfer(0, -1, 1'b0, 1'b0);

    req_data = 32'h5A3C_96E1;
    req = 4'b1111;
    for (int i = 0; i < N; i++) run_xfer(0, 0, 1'b0, 1'b0);
    set_req(0);
    run_xfer(0, 0, 1'b0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && ($urandom % 2 == 0)) set_req(i);
      if (req == '0) set_req(int'($urandom % N));
      run_xfer(int'($urandom % 3),
               ($urandom % 8 == 0) ? -1 : int'($urandom % 5),
               ($urandom % 4 == 0), 1'($urandom));
    end

    req = '0;
    set_req(2);
    transmit_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_pre_tx_ctrl", 32'(tx_ctrl), 32'd1);
    transmit_ready = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    #1;
    check_idle("async_rst");
    check_eq("async_rst_bit", 32'(bit_out), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_idle("held_rst");
    end
    nrst = 1'b1;
    mptr = 0;
    req = '0;
    set_req(1);
    set_req(3);
    run_xfer(0, 1, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
